// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: field-level micro-op in, encoded RV32I word + word address out.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_type;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_type, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: one-register output stage, 1-cycle latency, in_ready = !flush & (!out_valid | out_ready).
// ENC_RANGE_CHECK_EN: reject out-of-range immediates instead of truncating them.
module instr_encoder #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  instr_encoder_if.slave      bus,
  output logic                err,
  output logic                wrapped
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_err;
  logic              r_wrapped;

  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_is_shift;
  logic        w_class_ok;
  logic        w_range_ok;
  logic [31:0] w_instr;
  logic [31:0] w_imm;

  assign w_imm      = bus.in_imm;
  assign w_is_shift = (bus.in_funct3 == 3'b001) || (bus.in_funct3 == 3'b101);

  always_comb begin
    w_instr    = '0;
    w_class_ok = 1'b1;
    case (bus.in_type)
      3'd0: w_instr = {1'b0, bus.in_funct7b5, 5'b0, bus.in_rs2, bus.in_rs1,
                       bus.in_funct3, bus.in_rd, OP_R};
      3'd1: begin
        if (w_is_shift)
          w_instr = {1'b0, bus.in_funct7b5, 5'b0, w_imm[4:0], bus.in_rs1,
                     bus.in_funct3, bus.in_rd, OP_I};
        else
          w_instr = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_I};
      end
      3'd2: w_instr = {w_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      3'd3: w_instr = {w_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                       w_imm[4:0], OP_STORE};
      3'd4: w_instr = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1,
                       bus.in_funct3, w_imm[4:1], w_imm[11], OP_BRANCH};
      3'd5: w_instr = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                       bus.in_rd, OP_JAL};
      default: w_class_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] w_simm;
  assign w_simm = $signed(w_imm);

  always_comb begin
    w_range_ok = 1'b1;
    case (bus.in_type)
      3'd1: begin
        if (w_is_shift)
          w_range_ok = (w_simm >= 0) && (w_simm <= 31);
        else
          w_range_ok = (w_simm >= -2048) && (w_simm <= 2047);
      end
      3'd2, 3'd3: w_range_ok = (w_simm >= -2048) && (w_simm <= 2047);
      3'd4: w_range_ok = (w_simm >= -4096) && (w_simm <= 4094) && !w_imm[0];
      3'd5: w_range_ok = (w_simm >= -1048576) && (w_simm <= 1048574) && !w_imm[0];
      default: w_range_ok = 1'b1;
    endcase
  end
`else
  // Upper immediate bits are simply truncated away when no range check is built in.
  logic w_unused_imm;
  assign w_unused_imm = ^w_imm[31:21];
  assign w_range_ok   = 1'b1;
`endif

  assign bus.in_ready = !flush && (!r_out_valid || bus.out_ready);
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_out_fire   = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= BASE_ADDR;
      r_cnt       <= BASE_ADDR;
      r_err       <= 1'b0;
      r_wrapped   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_cnt       <= BASE_ADDR;
      r_err       <= 1'b0;
      r_wrapped   <= 1'b0;
    end else if (w_in_fire) begin
      // A rejected request still drains the register: in_ready implies it was empty or handing off.
      if (w_class_ok && w_range_ok) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_instr;
        r_out_addr  <= r_cnt;
        r_cnt       <= r_cnt + 1'b1;
        if (r_cnt == {ADDR_W{1'b1}})
          r_wrapped <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
        r_err       <= 1'b1;
      end
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_addr  = r_out_addr;
  assign err           = r_err;
  assign wrapped       = r_wrapped;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, rejects, backpressure, wrap/flush (ADDR_W=2 instance), async reset.
module tb_instr_encoder;
  logic clk;
  logic reset_n;
  logic flush;
  logic err, wrapped;
  logic err2, wrapped2;

  int total;
  int bad;
  logic [7:0] exp_addr;

  instr_encoder_if #(.ADDR_W(8)) bus ();
  instr_encoder_if #(.ADDR_W(2)) bus2 ();

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus), .err(err), .wrapped(wrapped)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus2), .err(err2), .wrapped(wrapped2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  t;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic set_fields(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                            input logic [31:0] imm);
    bus.in_type     = t;
    bus.in_rd       = rd;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_imm      = imm;
  endtask

  // Presents one request and returns #1 after the edge on which it was accepted.
  task automatic req(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                     input logic [31:0] imm);
    int n;
    set_fields(t, rd, rs1, rs2, f3, f7, imm);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL req_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    bus2.in_type = 3'd0; bus2.in_rd = 5'd3; bus2.in_rs1 = 5'd1; bus2.in_rs2 = 5'd2;
    bus2.in_funct3 = 3'd0; bus2.in_funct7b5 = 1'b0; bus2.in_imm = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.out_instr !== 32'd0) begin bad++; $display("FAIL reset_out_instr: got %h want 00000000", bus.out_instr); end
    total++; if (bus.out_addr !== 8'd0) begin bad++; $display("FAIL reset_out_addr: got %0d want 0", bus.out_addr); end
    total++; if (err !== 1'b0 || wrapped !== 1'b0) begin bad++; $display("FAIL reset_sticky: err=%b wrapped=%b want 0 0", err, wrapped); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    exp_addr = 8'd0;
  endtask

  task automatic test_encode();
    vecs[0] = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,          32'h002081B3};
    vecs[1] = '{3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,          32'h402081B3};
    vecs[2] = '{3'd2, 5'd5, 5'd0, 5'd9, 3'd2, 1'b0, 32'd8,          32'h00802283};
    vecs[3] = '{3'd3, 5'd7, 5'd2, 5'd5, 3'd2, 1'b0, 32'd4,          32'h00512223};
    vecs[4] = '{3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFFC,   32'hFE208EE3};
    vecs[5] = '{3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,          32'h008000EF};
    vecs[6] = '{3'd1, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'd3,          32'h00311093};
    vecs[7] = '{3'd1, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3,          32'h40315093};
    vecs[8] = '{3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 1'b1, 32'hFFFFFFFF,   32'hFFF10093};
    for (int i = 0; i < 9; i++) begin
      req(vecs[i].t, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== vecs[i].exp || bus.out_addr !== exp_addr) begin
        bad++;
        $display("FAIL encode[%0d]: valid=%b instr=%h addr=%0d want 1 %h %0d",
                 i, bus.out_valid, bus.out_instr, bus.out_addr, vecs[i].exp, exp_addr);
      end
      exp_addr++;
    end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL encode_err: got %b want 0", err); end
  endtask

  task automatic test_reject();
    req(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reject_class_valid: got %b want 0", bus.out_valid); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL reject_class_err: got %b want 1", err); end
`ifdef ENC_RANGE_CHECK_EN
    req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reject_branch_range: valid=%b want 0", bus.out_valid); end
    req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reject_jal_odd: valid=%b want 0", bus.out_valid); end
    req(3'd1, 5'd1, 5'd2, 5'd0, 3'd1, 1'b0, 32'd32);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reject_shamt: valid=%b want 0", bus.out_valid); end
`else
    req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4096);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h80208063 || bus.out_addr !== exp_addr) begin
      bad++;
      $display("FAIL branch_truncate: valid=%b instr=%h addr=%0d want 1 80208063 %0d",
               bus.out_valid, bus.out_instr, bus.out_addr, exp_addr);
    end
    exp_addr++;
`endif
    req(3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hFFF10093 || bus.out_addr !== exp_addr) begin
      bad++;
      $display("FAIL after_reject: valid=%b instr=%h addr=%0d want 1 fff10093 %0d",
               bus.out_valid, bus.out_instr, bus.out_addr, exp_addr);
    end
    exp_addr++;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    a = exp_addr;
    bus.out_ready = 1'b0;
    set_fields(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    set_fields(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.out_instr !== 32'h002081B3 || bus.out_addr !== a) begin
        bad++;
        $display("FAIL hold[%0d]: rdy=%b valid=%b instr=%h addr=%0d want 0 1 002081b3 %0d",
                 i, bus.in_ready, bus.out_valid, bus.out_instr, bus.out_addr, a);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h008000EF || bus.out_addr !== a + 8'd1) begin
      bad++;
      $display("FAIL release_1: valid=%b instr=%h addr=%0d want 1 008000ef %0d",
               bus.out_valid, bus.out_instr, bus.out_addr, a + 8'd1);
    end
    set_fields(3'd2, 5'd5, 5'd0, 5'd0, 3'd2, 1'b0, 32'd8);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00802283 || bus.out_addr !== a + 8'd2) begin
      bad++;
      $display("FAIL release_2: valid=%b instr=%h addr=%0d want 1 00802283 %0d",
               bus.out_valid, bus.out_instr, bus.out_addr, a + 8'd2);
    end
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain: valid=%b want 0", bus.out_valid); end
    exp_addr = a + 8'd3;
  endtask

  task automatic test_wrap_flush();
    bus2.out_ready = 1'b1;
    bus2.in_type = 3'd0;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus2.out_valid !== 1'b1 || bus2.out_addr !== 2'(i)) begin
        bad++;
        $display("FAIL wrap_addr[%0d]: valid=%b addr=%0d want 1 %0d", i, bus2.out_valid, bus2.out_addr, i % 4);
      end
      if (i == 2) begin
        total++; if (wrapped2 !== 1'b0) begin bad++; $display("FAIL wrap_early: wrapped=%b want 0", wrapped2); end
      end
    end
    total++; if (wrapped2 !== 1'b1) begin bad++; $display("FAIL wrap_flag: wrapped=%b want 1", wrapped2); end
    bus2.in_type = 3'd7;
    @(posedge clk); #1;
    total++; if (err2 !== 1'b1 || bus2.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_reject: err=%b valid=%b want 1 0", err2, bus2.out_valid); end
    bus2.in_type = 3'd0;
    bus2.out_ready = 1'b0;
    @(posedge clk); #1;
    total++; if (bus2.out_valid !== 1'b1 || bus2.out_addr !== 2'd1) begin bad++; $display("FAIL held_word: valid=%b addr=%0d want 1 1", bus2.out_valid, bus2.out_addr); end
    flush = 1'b1;
    #1;
    total++; if (bus2.in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", bus2.in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    bus2.in_valid = 1'b0;
    total++;
    if (bus2.out_valid !== 1'b0 || err2 !== 1'b0 || wrapped2 !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: valid=%b err=%b wrapped=%b want 0 0 0", bus2.out_valid, err2, wrapped2);
    end
    bus2.out_ready = 1'b1;
    bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    total++; if (bus2.out_valid !== 1'b1 || bus2.out_addr !== 2'd0) begin bad++; $display("FAIL flush_restart: valid=%b addr=%0d want 1 0", bus2.out_valid, bus2.out_addr); end
    exp_addr = 8'd0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    total++; if (bus.out_valid !== 1'b1 || bus.out_addr !== exp_addr) begin bad++; $display("FAIL pre_reset_word: valid=%b addr=%0d want 1 %0d", bus.out_valid, bus.out_addr, exp_addr); end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== 8'd0 || bus.out_instr !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: valid=%b addr=%0d instr=%h want 0 0 00000000", bus.out_valid, bus.out_addr, bus.out_instr);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_encode();
    test_reject();
    test_back_to_back();
    test_wrap_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
